// File: rtl/kda_scheduler_if.sv
// kda_scheduler_if
//   Bundles the job, core-dispatch, core-result and output-stream signals of
//   kda_scheduler. Signal names keep the scheduler's point of view (_i = into
//   the scheduler, _o = out of it).
//   Modports:
//     slave  - the scheduler itself
//     master - the environment (job source, pbkdf2 cores, key consumer)
//   Signals:
//     job_words_i, job_v_i, job_ready_o, abort_i, busy_o, done_o : job control
//     core_v_o, core_ready_i, core_idx_o                          : dispatch
//     core_v_i, core_hash_i, core_yumi_o                          : results
//     data_o, v_o, yumi_i                                         : key stream
interface kda_scheduler_if #(
  parameter int NUM_CORES  = 4,
  parameter int MAX_BLOCKS = 8,
  parameter int HASH_W     = 256,
  parameter int DATA_W     = 64
);
  localparam int WPB = HASH_W / DATA_W;
  localparam int JW  = $clog2(MAX_BLOCKS * WPB + 1);

  logic [JW-1:0]               job_words_i;
  logic                        job_v_i;
  logic                        job_ready_o;
  logic                        abort_i;
  logic                        busy_o;
  logic                        done_o;
  logic [NUM_CORES-1:0]        core_v_o;
  logic [NUM_CORES-1:0]        core_ready_i;
  logic [31:0]                 core_idx_o;
  logic [NUM_CORES-1:0]        core_v_i;
  logic [NUM_CORES*HASH_W-1:0] core_hash_i;
  logic [NUM_CORES-1:0]        core_yumi_o;
  logic [DATA_W-1:0]           data_o;
  logic                        v_o;
  logic                        yumi_i;

  modport slave (
    input  job_words_i, job_v_i, abort_i, core_ready_i, core_v_i,
           core_hash_i, yumi_i,
    output job_ready_o, busy_o, done_o, core_v_o, core_idx_o, core_yumi_o,
           data_o, v_o
  );

  modport master (
    output job_words_i, job_v_i, abort_i, core_ready_i, core_v_i,
           core_hash_i, yumi_i,
    input  job_ready_o, busy_o, done_o, core_v_o, core_idx_o, core_yumi_o,
           data_o, v_o
  );
endinterface

// File: rtl/kda_scheduler.sv
// kda_scheduler
//   Splits a key-derivation job into HASH_W-bit PBKDF2 blocks, hands block
//   indices round-robin to NUM_CORES external cores, collects results in any
//   order, and streams the derived key out in block order, DATA_W bits per
//   word, most-significant word first, truncated to the requested length.
//   Ports:
//     clk_i        - clock, rising edge
//     reset_n_i    - asynchronous active-low reset
//     bus          - kda_scheduler_if.slave (job, dispatch, results, stream)
//     dbg_state_o  - current FSM state (IDLE=0, RUN=1, ABORT=2, DONE=3)
//
//   Handshakes:
//     job     : accepted on a cycle with job_v_i && job_ready_o.
//     dispatch: core_v_o[c] is only raised when core_ready_i[c] is high, so
//               a raised core_v_o[c] is the transfer (same cycle).
//     results : core_v_i[c] is held by the core; core_yumi_o[c] acknowledges
//               it in the cycle it is high.
//     stream  : v_o/data_o hold until yumi_i; a word moves on v_o && yumi_i.
module kda_scheduler #(
  parameter int NUM_CORES  = 4,
  parameter int MAX_BLOCKS = 8,
  parameter int HASH_W     = 256,
  parameter int DATA_W     = 64
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  kda_scheduler_if.slave   bus,
  output logic [1:0]       dbg_state_o
);
  localparam int WPB  = HASH_W / DATA_W;
  localparam int MAXW = MAX_BLOCKS * WPB;
  localparam int JW   = $clog2(MAXW + 1);
  // Block counters run 1..MAX_BLOCKS+1 (next_blk passes nblk by one).
  localparam int BW   = $clog2(MAX_BLOCKS + 2);
  localparam int BIW  = (MAX_BLOCKS > 1) ? $clog2(MAX_BLOCKS) : 1;
  localparam int OW   = (WPB > 1) ? $clog2(WPB) : 1;
  localparam int CW   = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_ABORT, S_DONE} state_t;

  state_t                r_state, w_next;
  logic [JW-1:0]         r_words, r_sent;
  logic [BW-1:0]         r_nblk, r_next_blk, r_out_blk;
  logic [OW-1:0]         r_out_word;
  logic [CW-1:0]         r_rr;
  logic [NUM_CORES-1:0]  r_busy;
  logic [MAX_BLOCKS-1:0] r_have;
  logic [BW-1:0]         r_tag [NUM_CORES];
  logic [HASH_W-1:0]     r_buf [MAX_BLOCKS];

  logic [JW-1:0]         w_job_words;
  logic [BW-1:0]         w_job_nblk;
  logic                  w_col_v, w_disp_v, w_disp_ok;
  logic [CW-1:0]         w_col_c, w_disp_c, w_cand;
  logic [NUM_CORES-1:0]  w_yumi, w_core_v, w_elig;
  logic [BIW-1:0]        w_col_idx, w_out_idx;
  logic [HASH_W-1:0]     w_col_hash, w_out_blk_data;
  logic [DATA_W-1:0]     w_word;
  logic                  w_v, w_fire, w_last;

  assign dbg_state_o = r_state;

  // Oversized requests are clamped to what the buffer can hold.
  assign w_job_words = (bus.job_words_i > JW'(MAXW)) ? JW'(MAXW) : bus.job_words_i;
  assign w_job_nblk  = BW'((int'(w_job_words) + WPB - 1) / WPB);

  // Collect: lowest-index core with a result that we actually dispatched to.
  always_comb begin
    w_col_v = 1'b0;
    w_col_c = '0;
    if (r_state == S_RUN || r_state == S_ABORT) begin
      for (int c = NUM_CORES - 1; c >= 0; c--) begin
        if (bus.core_v_i[c] && r_busy[c]) begin
          w_col_v = 1'b1;
          w_col_c = CW'(c);
        end
      end
    end
    w_yumi          = '0;
    w_yumi[w_col_c] = w_col_v;
  end

  assign w_col_idx  = BIW'(r_tag[w_col_c] - 1'b1);
  assign w_col_hash = HASH_W'(bus.core_hash_i >> (int'(w_col_c) * HASH_W));

  // A core being acknowledged this cycle is free again, so it may take a new
  // block in the same cycle.
  assign w_elig    = bus.core_ready_i & ~(r_busy & ~w_yumi);
  assign w_disp_ok = (r_state == S_RUN) && !bus.abort_i && (r_next_blk <= r_nblk);

  // Dispatch: first eligible core after the last one served.
  always_comb begin
    w_disp_v = 1'b0;
    w_disp_c = '0;
    w_cand   = '0;
    if (w_disp_ok) begin
      for (int k = 1; k <= NUM_CORES; k++) begin
        w_cand = CW'((int'(r_rr) + k) % NUM_CORES);
        if (!w_disp_v && w_elig[w_cand]) begin
          w_disp_v = 1'b1;
          w_disp_c = w_cand;
        end
      end
    end
    w_core_v           = '0;
    w_core_v[w_disp_c] = w_disp_v;
  end

  // Stream side.
  assign w_out_idx      = BIW'(r_out_blk - 1'b1);
  assign w_out_blk_data = r_buf[w_out_idx];
  assign w_word         = DATA_W'(w_out_blk_data >> (DATA_W * (WPB - 1 - int'(r_out_word))));
  assign w_v            = (r_state == S_RUN) && r_have[w_out_idx];
  assign w_fire         = w_v && bus.yumi_i;
  assign w_last         = w_fire && ((r_sent + 1'b1) == r_words);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.job_v_i) w_next = (w_job_words == '0) ? S_DONE : S_RUN;
      S_RUN:   if (bus.abort_i) w_next = S_ABORT;
               else if (w_last) w_next = S_DONE;
      S_ABORT: if (r_busy == '0) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.job_ready_o = (r_state == S_IDLE);
    bus.busy_o      = (r_state != S_IDLE);
    bus.done_o      = (r_state == S_DONE);
    bus.core_v_o    = w_core_v;
    bus.core_idx_o  = w_disp_v ? 32'(r_next_blk) : 32'd0;
    bus.core_yumi_o = w_yumi;
    bus.v_o         = w_v;
    bus.data_o      = w_v ? w_word : '0;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state    <= S_IDLE;
      r_words    <= '0;
      r_sent     <= '0;
      r_nblk     <= '0;
      r_next_blk <= '0;
      r_out_blk  <= '0;
      r_out_word <= '0;
      r_rr       <= CW'(NUM_CORES - 1);
      r_busy     <= '0;
      r_have     <= '0;
      for (int c = 0; c < NUM_CORES; c++) r_tag[c] <= '0;
    end else begin
      r_state <= w_next;
      r_busy  <= (r_busy & ~w_yumi) | w_core_v;

      if (r_state == S_IDLE && bus.job_v_i) begin
        r_words    <= w_job_words;
        r_nblk     <= w_job_nblk;
        r_next_blk <= BW'(1);
        r_out_blk  <= BW'(1);
        r_out_word <= '0;
        r_sent     <= '0;
        r_have     <= '0;
      end

      if (w_disp_v) begin
        r_tag[w_disp_c] <= r_next_blk;
        r_rr            <= w_disp_c;
        r_next_blk      <= r_next_blk + 1'b1;
      end

      if (w_fire) begin
        r_sent <= r_sent + 1'b1;
        if (r_out_word == OW'(WPB - 1)) begin
          r_out_word        <= '0;
          r_have[w_out_idx] <= 1'b0;
          r_out_blk         <= r_out_blk + 1'b1;
        end else begin
          r_out_word <= r_out_word + 1'b1;
        end
      end

      // Results landing during ABORT are acknowledged but dropped.
      if (w_col_v && r_state == S_RUN) r_have[w_col_idx] <= 1'b1;
    end
  end

  // Result buffer needs no reset: a block is only read once its have bit is set.
  always_ff @(posedge clk_i) begin
    if (w_col_v && r_state == S_RUN) r_buf[w_col_idx] <= w_col_hash;
  end
endmodule
